// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam int unsigned IMEM_WORDS_DEF = 2048;
   localparam int unsigned FIFO_DEPTH_DEF = 2;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer: circular storage with flush; the caller guarantees no push into a full buffer without a pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head,
   output logic               full,
   output logic               empty,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t       store_q [DEPTH];
   logic [PTR_W-1:0]   wr_q;
   logic [PTR_W-1:0]   rd_q;
   logic [CNT_W-1:0]   count_q;
   logic               pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign pop_ok = pop && (count_q != '0);

   // Storage, pointers and occupancy; flush wins over push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         store_q <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            store_q[wr_q] <= push_data;
            wr_q          <= ptr_inc(wr_q);
         end
         if (pop_ok) begin
            rd_q <= ptr_inc(rd_q);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop_ok);
      end
   end

   assign head  = store_q[rd_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, one outstanding memory read, buffered delivery to decode, redirect flush.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_address,
   output logic [31:0] mem_in,
   output logic        mem_en,
   output logic        mem_r_w,
   input  logic [31:0] mem_out,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   fetch_state_t       state_q;
   fetch_state_t       state_d;
   logic [31:0]        pc;
   logic               inflight;
   logic [31:0]        inflight_pc;
   logic               pop;
   logic               push;
   logic               credit;
   fetch_entry_t       push_entry;
   fetch_entry_t       head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   assign mem_r_w     = 1'b0;
   assign mem_in      = 32'h0000_0000;
   assign mem_address = (pc >> 2) % IMEM_WORDS;

   assign inst_valid = !fifo_empty;
   assign inst_data  = head.inst;
   assign inst_pc    = head.pc;
   assign pop        = inst_valid && inst_ready;

   // Buffer slots not yet claimed by stored entries or the outstanding read.
   assign credit = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;

   // Returning read data is pushed unless a redirect is discarding it this cycle.
   assign push       = inflight && !redirect_valid && (!fifo_full || pop);
   assign push_entry = '{pc: inflight_pc, inst: mem_out};

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and memory request enable.
   always_comb begin
      state_d = state_q;
      mem_en  = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            mem_en = !redirect_valid && (credit || pop);
         end
      endcase
   end

   // PC and outstanding-request tracking; a redirect cancels the in-flight read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0000_0000;
      end else if (redirect_valid) begin
         pc       <= redirect_pc & 32'hFFFF_FFFC;
         inflight <= 1'b0;
      end else begin
         inflight <= mem_en;
         if (mem_en) begin
            pc          <= pc + 32'd4;
            inflight_pc <= pc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 2048, instruction-memory size in words; the fetch word address wraps modulo IMEM_WORDS.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of instruction buffer entries.
REQ-004 SHALL have ports: clk in 1, the single clock, rising edge; rst in 1, asynchronous, active-high reset.
REQ-005 SHALL have memory-side ports: mem_address out 32 (word index); mem_in out 32; mem_en out 1; mem_r_w out 1 (0 = read); mem_out in 32 (read data, valid the cycle after the request).
REQ-006 SHALL have redirect ports: redirect_valid in 1; redirect_pc in 32 (byte address).
REQ-007 SHALL have decode-side ports: inst_valid out 1; inst_ready in 1; inst_data out 32; inst_pc out 32.

Function
REQ-008 SHALL hold a byte PC; mem_address = (pc >> 2) mod IMEM_WORDS; after each issued request, pc advances by 4.
REQ-009 SHALL tie mem_r_w = 0 and mem_in = 0 permanently.
REQ-010 SHALL implement FSM states BOOT and RUN: reset enters BOOT; BOOT -> RUN unconditionally after one cycle; RUN persists until reset.
REQ-011 SHALL drive mem_en low in BOOT.
REQ-012 SHALL drive mem_en combinationally high in RUN when all hold: redirect_valid = 0; and (occupancy + inflight < FIFO_DEPTH, or a pop occurs this cycle).
REQ-013 SHALL track at most one in-flight request (inflight flag, inflight_pc); data on mem_out in the following cycle SHALL be pushed as {inflight_pc, mem_out}.
REQ-014 SHALL define a pop as inst_valid && inst_ready; inst_valid = FIFO not empty; inst_data/inst_pc = head entry, stable while inst_valid && !inst_ready.
REQ-015 SHALL sustain one instruction per cycle with inst_ready held high; first-fetch latency is request in cycle 1 after reset release and inst_valid in cycle 3.
REQ-016 SHALL, when redirect_valid = 1: empty the FIFO, cancel the in-flight request so its data is never pushed, and load pc <= {redirect_pc[31:2], 2'b00}; the first request to the new pc SHALL issue the next cycle.
REQ-017 SHALL give redirect priority over a simultaneous pop, push or issue; the pop in that cycle is void.
REQ-018 SHALL allow simultaneous push and pop at full occupancy with no loss or duplication.
REQ-019 SHALL never overflow the FIFO; REQ-012 credit guarantees this, and the bench asserts it.
REQ-020 SHALL wrap the word index from IMEM_WORDS-1 to 0; pc itself increments modulo 2^32.

Reset
REQ-021 SHALL, on rst assertion, asynchronously set: pc = RESET_PC, FSM = BOOT, FIFO empty, inflight = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, mem_en = 0, mem_address = RESET_PC >> 2.
REQ-022 SHALL discard any data returning on mem_out in the cycle after reset release; no push occurs.
REQ-023 SHALL be reset-safe mid-operation: a reset asserted with a full FIFO and a request in flight yields exactly the REQ-021 state.

Structure
REQ-024 SHALL place in a shared package fetch_pkg: FSM state enum (BOOT, RUN), typedef fetch_entry_t {pc[31:0], inst[31:0]}, and default constants RESET_PC_DEF, IMEM_WORDS_DEF, FIFO_DEPTH_DEF.
REQ-025 SHALL implement the buffer as sub-module fetch_fifo (parameter DEPTH, push/pop/flush, full/empty/count, async active-high reset).
REQ-026 SHALL contain no combinational path from mem_out to any output.

Verification
REQ-027 Reset release with ready = 1 and memory words 0..3 = A0..A3 -> mem_en high from cycle 1; inst_valid from cycle 3; (pc, inst) = (0, A0), (4, A1), (8, A2) on consecutive cycles.
REQ-028 inst_ready = 0 for 6 cycles -> FIFO holds 2 entries; mem_en low; head (0, A0) stable; on ready = 1 the stream resumes in order, no gap after the first pop.
REQ-029 Redirect to 0x0000_0042 while full and in flight -> next cycle inst_valid = 0 and mem_address = 0x10; first delivered entry is (0x40, word[0x10]); stale data never appears.
REQ-030 Redirect coincident with pop -> popped entry not re-delivered; no pre-redirect entry delivered afterwards.
REQ-031 Redirect to 0x1FFC (word 2047) -> entries (0x1FFC, word[2047]), (0x2000, word[0]).
REQ-032 rst pulsed mid-stream, asynchronous to clk -> all outputs reach REQ-021 values immediately; the sequence restarts from RESET_PC as in REQ-027.
